sram_cache_arbiter: RTL and testbench

- Shares one single-port cache SRAM (sram_cache instance, 1-cycle read latency) between NUM_REQ requesters with round-robin priority.
- Zero-fills the array after reset and on a flush request, and holds all grants off while it does so.
- Sits between the cache controller ports (refill, lookup, writeback) and the tag/data SRAM wrapper.

---
 rtl/sram_cache_arb_pkg.sv | 36 +++
 rtl/rr_arbiter.sv | 51 +++++
 rtl/sram_cache_arbiter.sv | 136 +++++++++++++
 tb/tb_sram_cache_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_cache_arb_pkg.sv
// Shared types and helpers for the cache SRAM arbiter and its round-robin core.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package sram_cache_arb_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int MAX_REQ        = 8;
    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_NUM_WORDS  = 256;
    localparam int DEF_AW         = $clog2(DEF_NUM_WORDS);
    localparam int DEF_BE_W       = DEF_DATA_WIDTH / 8;

    // First asserted request at or above ptr, wrapping modulo n. Scanning downward
    // lets the lowest rotated position overwrite the others, so no early exit is needed.
    function automatic logic [2:0] rr_winner(input logic [MAX_REQ-1:0] req,
                                             input logic [2:0]         ptr,
                                             input int                 n);
        logic [2:0] win;
        int         idx;
        win = 3'd0;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (i < n) begin
                idx = (int'(ptr) + i) % n;
                if (req[idx[2:0]]) begin
                    win = idx[2:0];
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus winner index, pointer advances past each winner.
// Latency: grant combinational from req_i; pointer update takes effect next cycle.
// Backpressure: en_i low suppresses all grants and freezes the pointer.
module rr_arbiter
    import sram_cache_arb_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       en_i,
    input  logic [NUM_REQ-1:0]         req_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o,
    output logic                       vld_o
);

    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0]      r_ptr;
    logic [IW-1:0]      w_idx;
    logic [MAX_REQ-1:0] w_req_ext;
    logic               w_vld;

    always_comb begin
        w_req_ext                = '0;
        w_req_ext[NUM_REQ-1:0]   = req_i;
    end

    assign w_idx = IW'(rr_winner(w_req_ext, 3'(r_ptr), NUM_REQ));
    assign w_vld = en_i & (|req_i);

    always_comb begin
        gnt_o = '0;
        if (w_vld) begin
            gnt_o[w_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr <= '0;
        end else if (w_vld) begin
            r_ptr <= (w_idx == IW'(NUM_REQ - 1)) ? '0 : w_idx + IW'(1);
        end
    end

    assign idx_o = w_idx;
    assign vld_o = w_vld;

endmodule

// File: rtl/sram_cache_arbiter.sv
// Shares one single-port cache SRAM among NUM_REQ requesters; zero-fills it after reset/flush.
// Latency: grant and SRAM drive same cycle as request; read data valid one cycle after grant.
// Backpressure: requesters hold req_i until granted; no grants during a sweep or a flush cycle.
module sram_cache_arbiter
    import sram_cache_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 3,
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int NUM_WORDS  = DEF_NUM_WORDS,
    parameter  int INIT_EN    = 1,
    localparam int AW         = $clog2(NUM_WORDS),
    localparam int BW         = DATA_WIDTH / 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    output logic                          init_busy_o,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ-1:0]            we_i,
    input  logic [NUM_REQ*AW-1:0]         addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
    input  logic [NUM_REQ*BW-1:0]         be_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            rvalid_o,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic                          sram_req_o,
    output logic                          sram_we_o,
    output logic [AW-1:0]                 sram_addr_o,
    output logic [DATA_WIDTH-1:0]         sram_wdata_o,
    output logic [BW-1:0]                 sram_be_o,
    input  logic [DATA_WIDTH-1:0]         sram_rdata_i
);

    localparam int            IW   = $clog2(NUM_REQ);
    localparam logic [AW-1:0] LAST = AW'(NUM_WORDS - 1);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [AW-1:0]      r_cnt;
    logic [NUM_REQ-1:0] r_rvld;
    logic [NUM_REQ-1:0] w_gnt;
    logic [IW-1:0]      w_idx;
    logic               w_vld;
    logic               w_flush;
    logic               w_arb_en;

    assign w_flush  = (INIT_EN != 0) && flush_i && (r_state == ST_RUN);
    assign w_arb_en = (r_state == ST_RUN) && !w_flush;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (w_arb_en),
        .req_i  (req_i),
        .gnt_o  (w_gnt),
        .idx_o  (w_idx),
        .vld_o  (w_vld)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: if (r_cnt == LAST) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_flush)       w_state_nxt = ST_INIT;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (r_state == ST_INIT) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + AW'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    // Only reads return data; a flush cycle grants nothing, but last cycle's read still lands.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvld <= '0;
        end else begin
            r_rvld <= w_gnt & ~we_i;
        end
    end

    // While reset is held the sweep must not touch the array.
    always_comb begin
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;
        case (r_state)
            ST_INIT: begin
                if (rst_ni) begin
                    sram_req_o  = 1'b1;
                    sram_we_o   = 1'b1;
                    sram_addr_o = r_cnt;
                    sram_be_o   = '1;
                end
            end
            ST_RUN: begin
                if (w_vld) begin
                    sram_req_o   = 1'b1;
                    sram_we_o    = we_i[w_idx];
                    sram_addr_o  = addr_i[int'(w_idx)*AW +: AW];
                    sram_wdata_o = wdata_i[int'(w_idx)*DATA_WIDTH +: DATA_WIDTH];
                    sram_be_o    = be_i[int'(w_idx)*BW +: BW];
                end
            end
            default: ;
        endcase
    end

    assign gnt_o       = w_gnt;
    assign rvalid_o    = r_rvld;
    assign rdata_o     = sram_rdata_i;
    assign init_busy_o = (r_state == ST_INIT);

    a_gnt_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o));
    a_no_gnt_init : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                     (r_state == ST_INIT) |-> (gnt_o == '0));

endmodule

// File: tb/tb_sram_cache_arbiter.sv
// Directed bench for sram_cache_arbiter: sweep, round-robin, byte enables, flush, mid-run reset.
module tb_sram_cache_arbiter;
    import sram_cache_arb_pkg::*;

    localparam int N  = 3;
    localparam int DW = DEF_DATA_WIDTH;
    localparam int NW = DEF_NUM_WORDS;
    localparam int AW = DEF_AW;
    localparam int BW = DEF_BE_W;

    localparam logic [DW-1:0] W0 = 64'h0123_4567_89AB_CDEF;
    localparam logic [DW-1:0] W1 = 64'hFEDC_BA98_7654_3210;
    localparam logic [DW-1:0] W2 = 64'h0F0F_0F0F_F0F0_F0F0;
    localparam logic [DW-1:0] WD = 64'hDEAD_BEEF_1234_5678;
    localparam logic [DW-1:0] RD = 64'hDEAD_BEEF_0000_0000;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic            init_busy;
    logic [N-1:0]    req, we, gnt, rvalid;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N*BW-1:0] be;
    logic [DW-1:0]   rdata;
    logic            sram_req, sram_we;
    logic [AW-1:0]   sram_addr;
    logic [DW-1:0]   sram_wdata, sram_rdata;
    logic [BW-1:0]   sram_be;

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sram_cache_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .NUM_WORDS(NW), .INIT_EN(1)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .flush_i      (flush),
        .init_busy_o  (init_busy),
        .req_i        (req),
        .we_i         (we),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .be_i         (be),
        .gnt_o        (gnt),
        .rvalid_o     (rvalid),
        .rdata_o      (rdata),
        .sram_req_o   (sram_req),
        .sram_we_o    (sram_we),
        .sram_addr_o  (sram_addr),
        .sram_wdata_o (sram_wdata),
        .sram_be_o    (sram_be),
        .sram_rdata_i (sram_rdata)
    );

    // Behavioural SRAM: garbage while in reset so the sweep has something to erase.
    logic [DW-1:0] mem [NW];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NW; i++) mem[i] <= {32'hA5A5_A5A5, 32'(i)};
        end else if (sram_req) begin
            if (sram_we) begin
                for (int b = 0; b < BW; b++)
                    if (sram_be[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    typedef struct {
        logic [N-1:0]    req;
        logic [N-1:0]    we;
        logic [N*AW-1:0] addr;
        logic [DW-1:0]   wd;
        logic [BW-1:0]   be;
        logic [N-1:0]    gnt;
        logic [N-1:0]    rv;
        logic [DW-1:0]   rd;
    } vec_t;

    vec_t vt [16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [N-1:0] r, input logic [N-1:0] w,
                         input logic [N*AW-1:0] a, input logic [DW-1:0] d,
                         input logic [BW-1:0] b);
        req   = r;
        we    = w;
        addr  = a;
        wdata = {N{d}};
        be    = {N{b}};
    endtask

    initial begin
        logic [N*AW-1:0] a_rd;
        int nz;
        int busy_cnt;
        int k;
        int w;

        a_rd = {8'd12, 8'd11, 8'd10};
        // req, we, addr{a2,a1,a0}, wdata, be, exp gnt, exp rvalid, exp rdata
        vt[0]  = '{3'b111, 3'b111, a_rd, W0, 8'hFF, 3'b001, 3'b000, 64'h0};
        vt[1]  = '{3'b111, 3'b111, a_rd, W1, 8'hFF, 3'b010, 3'b000, 64'h0};
        vt[2]  = '{3'b111, 3'b111, a_rd, W2, 8'hFF, 3'b100, 3'b000, 64'h0};
        vt[3]  = '{3'b111, 3'b000, a_rd, 64'h0, 8'hFF, 3'b001, 3'b000, 64'h0};
        vt[4]  = '{3'b111, 3'b000, a_rd, 64'h0, 8'hFF, 3'b010, 3'b001, W0};
        vt[5]  = '{3'b111, 3'b000, a_rd, 64'h0, 8'hFF, 3'b100, 3'b010, W1};
        vt[6]  = '{3'b111, 3'b000, a_rd, 64'h0, 8'hFF, 3'b001, 3'b100, W2};
        vt[7]  = '{3'b000, 3'b000, a_rd, 64'h0, 8'hFF, 3'b000, 3'b001, W0};
        vt[8]  = '{3'b001, 3'b001, {8'd0, 8'd0, 8'd5}, WD, 8'hF0, 3'b001, 3'b000, 64'h0};
        vt[9]  = '{3'b100, 3'b000, {8'd5, 8'd0, 8'd0}, 64'h0, 8'hFF, 3'b100, 3'b000, 64'h0};
        vt[10] = '{3'b000, 3'b000, a_rd, 64'h0, 8'hFF, 3'b000, 3'b100, RD};
        vt[11] = '{3'b010, 3'b000, a_rd, 64'h0, 8'hFF, 3'b010, 3'b000, 64'h0};
        vt[12] = '{3'b011, 3'b000, a_rd, 64'h0, 8'hFF, 3'b001, 3'b010, W1};
        vt[13] = '{3'b011, 3'b000, a_rd, 64'h0, 8'hFF, 3'b010, 3'b001, W0};
        vt[14] = '{3'b111, 3'b000, a_rd, 64'h0, 8'hFF, 3'b100, 3'b010, W1};
        vt[15] = '{3'b000, 3'b000, a_rd, 64'h0, 8'hFF, 3'b000, 3'b100, W2};

        rst_n = 1'b0;
        flush = 1'b0;
        drive(3'b111, 3'b000, a_rd, 64'h0, 8'hFF);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(init_busy), 64'h1);
        chk("rst_gnt", 64'(gnt), 64'h0);
        chk("rst_rvalid", 64'(rvalid), 64'h0);
        chk("rst_sram_req", 64'(sram_req), 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < NW; i++) begin
            @(negedge clk);
            chk($sformatf("sweep%0d_ctl", i),
                64'({init_busy, gnt, sram_req, sram_we, sram_addr, sram_be}),
                64'({1'b1, 3'b000, 1'b1, 1'b1, AW'(i), 8'hFF}));
            chk($sformatf("sweep%0d_wdata", i), sram_wdata, 64'h0);
            @(posedge clk); #1;
        end
        nz = 0;
        for (int i = 0; i < NW; i++) if (mem[i] != '0) nz++;
        chk("sweep_zero", 64'(nz), 64'h0);

        for (int i = 0; i < 16; i++) begin
            drive(vt[i].req, vt[i].we, vt[i].addr, vt[i].wd, vt[i].be);
            @(negedge clk);
            chk($sformatf("r%0d_busy", i), 64'(init_busy), 64'h0);
            chk($sformatf("r%0d_gnt", i), 64'(gnt), 64'(vt[i].gnt));
            chk($sformatf("r%0d_rvalid", i), 64'(rvalid), 64'(vt[i].rv));
            if (vt[i].rv != '0) chk($sformatf("r%0d_rdata", i), rdata, vt[i].rd);
            chk($sformatf("r%0d_sram_req", i), 64'(sram_req), 64'(|vt[i].gnt));
            if (vt[i].gnt != '0) begin
                w = 0;
                for (int j = 0; j < N; j++) if (vt[i].gnt[j]) w = j;
                chk($sformatf("r%0d_sram_addr", i), 64'(sram_addr), 64'(vt[i].addr[w*AW +: AW]));
                chk($sformatf("r%0d_sram_we", i), 64'(sram_we), 64'(vt[i].we[w]));
            end
            @(posedge clk); #1;
        end

        // Flush: req0 read granted, then flush alongside a req1 read.
        drive(3'b001, 3'b000, a_rd, 64'h0, 8'hFF);
        @(negedge clk);
        chk("fl_pre_gnt", 64'(gnt), 64'b001);
        @(posedge clk); #1;
        drive(3'b010, 3'b000, a_rd, 64'h0, 8'hFF);
        flush = 1'b1;
        @(negedge clk);
        chk("fl_gnt", 64'(gnt), 64'h0);
        chk("fl_sram_req", 64'(sram_req), 64'h0);
        chk("fl_rvalid", 64'(rvalid), 64'b001);
        chk("fl_rdata", rdata, W0);
        chk("fl_busy", 64'(init_busy), 64'h0);
        @(posedge clk); #1;
        flush = 1'b0;
        busy_cnt = 0;
        k = 0;
        while (k < 400) begin
            @(negedge clk);
            if (!init_busy) break;
            busy_cnt++;
            chk($sformatf("fl_sweep%0d_gnt", k), 64'(gnt), 64'h0);
            flush = (k == 100);
            k++;
        end
        flush = 1'b0;
        chk("fl_sweep_len", 64'(busy_cnt), 64'd256);
        chk("fl_first_run_gnt", 64'(gnt), 64'b010);
        @(posedge clk); #1;
        drive(3'b000, 3'b000, a_rd, 64'h0, 8'hFF);
        @(negedge clk);
        chk("fl_rvalid1", 64'(rvalid), 64'b010);
        chk("fl_rdata1", rdata, 64'h0);
        @(posedge clk); #1;

        // Reset right after a read grant drops the pending return and restarts the sweep.
        drive(3'b100, 3'b000, a_rd, 64'h0, 8'hFF);
        @(negedge clk);
        chk("mr_gnt", 64'(gnt), 64'b100);
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive(3'b000, 3'b000, a_rd, 64'h0, 8'hFF);
        @(negedge clk);
        chk("mr_rvalid", 64'(rvalid), 64'h0);
        chk("mr_busy", 64'(init_busy), 64'h1);
        chk("mr_sram_req", 64'(sram_req), 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("mr_sweep%0d", i), 64'({rvalid, sram_req, sram_addr}),
                64'({3'b000, 1'b1, AW'(i)}));
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
